// File: rtl/ahb_master_port_pkg.sv
// Shared constants and state encoding for the AHB initiator port.
package ahb_master_port_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Slaves selected by these bits sit behind the bridge and grant more slowly.
    localparam logic [3:0] SEL_BRIDGE_MASK = 4'b1100;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StAddr,
        StData,
        StResp
    } state_e;

    function automatic logic is_bridge(input logic [3:0] sel);
        return |(sel & SEL_BRIDGE_MASK);
    endfunction

endpackage

// File: rtl/ahb_master_port_if.sv
// Command/response and bus-side signals of one AHB initiator port.
interface ahb_master_port_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_sel;
    logic          rsp_valid;
    logic          rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          hreq;
    logic [3:0]    sel;
    logic          hgrant;
    logic [AW-1:0] haddr;
    logic          hwrite;
    logic [1:0]    htrans;
    logic [DW-1:0] hwdata;
    logic [DW-1:0] hrdata;
    logic          hready_out;
    logic          hresp;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_sel,
        input  hgrant, hrdata, hready_out, hresp,
        output cmd_ready, rsp_valid, rsp_err, rsp_rdata,
        output hreq, sel, haddr, hwrite, htrans, hwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_sel,
        output hgrant, hrdata, hready_out, hresp,
        input  cmd_ready, rsp_valid, rsp_err, rsp_rdata,
        input  hreq, sel, haddr, hwrite, htrans, hwdata
    );

endinterface

// File: rtl/ahb_master_port.sv
// AHB initiator port: takes single-beat commands, requests the bus, runs address and data
// phases with error retry and timeout, and returns status plus read data.
module ahb_master_port
    import ahb_master_port_pkg::*;
#(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned TIMEOUT   = 255
) (
    input logic               hclk,
    input logic               hresetn,
    ahb_master_port_if.master bus
);

    localparam int unsigned TmoW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned RtyW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT);
    localparam logic [RtyW-1:0] RtyMax = RtyW'(MAX_RETRY);

    state_e        state_q, state_d;
    logic          write_q, write_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [RtyW-1:0] retry_q, retry_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          hreq_q, hreq_d;
    logic [3:0]    sel_q, sel_d;
    logic [AW-1:0] haddr_q, haddr_d;
    logic          hwrite_q, hwrite_d;
    logic [1:0]    htrans_q, htrans_d;
    logic [DW-1:0] hwdata_q, hwdata_d;
    logic          finish, finish_err;
    logic [TmoW-1:0] tmo_inc;

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        retry_d     = retry_q;
        tmo_d       = tmo_q;
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        hreq_d      = hreq_q;
        sel_d       = sel_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        htrans_d    = HTRANS_IDLE;
        hwdata_d    = hwdata_q;
        finish      = 1'b0;
        finish_err  = 1'b0;
        tmo_inc     = (tmo_q == TmoMax) ? tmo_q : tmo_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid && cmd_ready_q) begin
                    write_d     = bus.cmd_write;
                    addr_d      = bus.cmd_addr;
                    wdata_d     = bus.cmd_wdata;
                    retry_d     = '0;
                    tmo_d       = '0;
                    hreq_d      = 1'b1;
                    sel_d       = bus.cmd_sel;
                    cmd_ready_d = 1'b0;
                    state_d     = StReq;
                end
            end
            StReq: begin
                if (bus.hgrant) begin
                    state_d  = StAddr;
                    tmo_d    = '0;
                    htrans_d = HTRANS_NONSEQ;
                    haddr_d  = addr_q;
                    hwrite_d = write_q;
                end else if (tmo_q == TmoMax) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            StAddr: begin
                tmo_d = '0;
                if (!bus.hgrant) begin
                    state_d = StReq;
                end else begin
                    state_d = StData;
                    if (write_q) hwdata_d = wdata_q;
                end
            end
            StData: begin
                if (bus.hready_out) begin
                    if (!bus.hresp) begin
                        finish = 1'b1;
                        if (!write_q) rsp_rdata_d = bus.hrdata;
                    end else if (retry_q < RtyMax) begin
                        // Arbiter holds the grant across an error, so re-issue directly.
                        retry_d  = retry_q + 1'b1;
                        state_d  = StAddr;
                        htrans_d = HTRANS_NONSEQ;
                    end else begin
                        finish     = 1'b1;
                        finish_err = 1'b1;
                    end
                end else if (tmo_q == TmoMax) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            StResp: begin
                cmd_ready_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Dropping hreq in RESP forces at least one idle cycle before the next request.
        if (finish) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = finish_err;
            hreq_d      = 1'b0;
            sel_d       = 4'h0;
            htrans_d    = HTRANS_IDLE;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= StIdle;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            retry_q     <= '0;
            tmo_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            hreq_q      <= 1'b0;
            sel_q       <= 4'h0;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            htrans_q    <= HTRANS_IDLE;
            hwdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            retry_q     <= retry_d;
            tmo_q       <= tmo_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            hreq_q      <= hreq_d;
            sel_q       <= sel_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            htrans_q    <= htrans_d;
            hwdata_q    <= hwdata_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.hreq      = hreq_q;
    assign bus.sel       = sel_q;
    assign bus.haddr     = haddr_q;
    assign bus.hwrite    = hwrite_q;
    assign bus.htrans    = htrans_q;
    assign bus.hwdata    = hwdata_q;

endmodule

// File: tb/tb_ahb_master_port.sv
// Bench for ahb_master_port: arbiter/slave responder, queued expected responses, and a
// monitor that checks every rsp_valid pulse against them.
module tb_ahb_master_port;
    import ahb_master_port_pkg::*;

    localparam int unsigned AW        = 32;
    localparam int unsigned DW        = 32;
    localparam int unsigned MAX_RETRY = 3;
    localparam int unsigned TIMEOUT   = 255;

    typedef struct {
        logic          err;
        logic [DW-1:0] rdata;
        int            nonseq;
        int            lat;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            n_vec = 0;
    int            n_miss = 0;
    int            cyc = 0;
    int            nonseq_seen = 0;
    int            req_start = 0;
    logic          hreq_prev = 1'b0;
    logic          hclk = 1'b0;
    logic          hresetn = 1'b0;
    logic [DW-1:0] model_rdata = '0;

    ahb_master_port_if #(.AW(AW), .DW(DW)) bus ();

    ahb_master_port #(
        .AW(AW), .DW(DW), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)
    ) dut (
        .hclk(hclk),
        .hresetn(hresetn),
        .bus(bus)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Response monitor: independent of the stimulus process.
    always @(negedge hclk) begin
        cyc++;
        if (!hresetn) begin
            nonseq_seen = 0;
            hreq_prev   = 1'b0;
        end else begin
            if (bus.hreq && !hreq_prev) req_start = cyc;
            hreq_prev = bus.hreq;
            if (bus.htrans == HTRANS_NONSEQ) nonseq_seen++;
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_rsp: got rsp_valid, want none queued");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_err", 64'(bus.rsp_err), 64'(mon_e.err));
                    check("rsp_rdata", 64'(bus.rsp_rdata), 64'(mon_e.rdata));
                    check("nonseq_count", 64'(nonseq_seen), 64'(mon_e.nonseq));
                    check("resp_hreq_low", 64'(bus.hreq), 64'(0));
                    check("resp_sel_zero", 64'(bus.sel), 64'(0));
                    if (mon_e.lat > 0) check("tmo_latency", 64'(cyc - req_start), 64'(mon_e.lat));
                end
                nonseq_seen = 0;
            end
        end
    end

    // One command: gdly = negedges after hreq before grant, waits = wait states per attempt,
    // nerr = attempts answered with ERROR, abort = pulse reset in the first data cycle.
    task automatic run_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [3:0] s, input int gdly, input int waits, input int nerr,
                           input logic [DW-1:0] rd, input bit no_grant, input bit abort);
        exp_t e;
        int   budget;
        int   k;
        int   wait_left;
        int   attempt;
        bit   in_data;
        bit   done;

        budget = 0;
        while (!bus.cmd_ready && budget < 20) begin
            @(negedge hclk);
            budget++;
        end
        check("cmd_ready_idle", 64'(bus.cmd_ready), 64'(1));

        e.lat = 0;
        if (no_grant) begin
            e.err = 1'b1; e.nonseq = 0; e.lat = TIMEOUT + 1;
        end else if (waits > int'(TIMEOUT)) begin
            e.err = 1'b1; e.nonseq = 1;
        end else if (nerr > int'(MAX_RETRY)) begin
            e.err = 1'b1; e.nonseq = MAX_RETRY + 1;
        end else begin
            e.err = 1'b0; e.nonseq = nerr + 1;
            if (!wr && !abort) model_rdata = rd;
        end
        e.rdata = model_rdata;
        if (!abort) exp_q.push_back(e);

        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_sel   = s;
        bus.hrdata    = rd;
        @(negedge hclk);
        bus.cmd_valid = 1'b0;
        check("hreq_rise", 64'(bus.hreq), 64'(1));
        check("sel_out", 64'(bus.sel), 64'(s));
        check("cmd_ready_busy", 64'(bus.cmd_ready), 64'(0));
        bus.hgrant = !no_grant && gdly == 0;

        k = 0; in_data = 1'b0; attempt = 0; done = 1'b0; wait_left = 0;
        for (budget = 0; budget < 800 && !done; budget++) begin
            @(negedge hclk);
            if (bus.rsp_valid) begin
                done = 1'b1;
            end else if (abort && in_data) begin
                #2 hresetn = 1'b0;
                #1;
                check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
                check("rst_hreq", 64'(bus.hreq), 64'(0));
                check("rst_sel", 64'(bus.sel), 64'(0));
                check("rst_htrans", 64'(bus.htrans), 64'(0));
                check("rst_haddr", 64'(bus.haddr), 64'(0));
                check("rst_hwdata", 64'(bus.hwdata), 64'(0));
                check("rst_hwrite", 64'(bus.hwrite), 64'(0));
                check("rst_rsp", 64'({bus.rsp_valid, bus.rsp_err}), 64'(0));
                check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
                bus.hgrant = 1'b0;
                bus.hready_out = 1'b1;
                bus.hresp = 1'b0;
                repeat (2) @(negedge hclk);
                hresetn = 1'b1;
                model_rdata = '0;
                done = 1'b1;
            end else begin
                k++;
                if (!bus.hgrant) begin
                    check("hreq_held", 64'(bus.hreq), 64'(1));
                    check("sel_held", 64'(bus.sel), 64'(s));
                end
                if (!no_grant && k >= gdly) bus.hgrant = 1'b1;
                if (in_data && wr) check("hwdata_hold", 64'(bus.hwdata), 64'(wdata));
                if (in_data) begin
                    if (wait_left > 0) begin
                        bus.hready_out = 1'b0;
                        bus.hresp = 1'b0;
                        wait_left--;
                    end else begin
                        bus.hready_out = 1'b1;
                        bus.hresp = attempt < nerr;
                        attempt++;
                        in_data = 1'b0;
                    end
                end else begin
                    bus.hready_out = 1'b1;
                    bus.hresp = 1'b0;
                end
                if (bus.htrans == HTRANS_NONSEQ) begin
                    check("haddr", 64'(bus.haddr), 64'(addr));
                    check("hwrite", 64'(bus.hwrite), 64'(wr));
                    in_data = 1'b1;
                    wait_left = waits;
                end
            end
        end
        bus.hgrant = 1'b0;
        bus.hready_out = 1'b1;
        bus.hresp = 1'b0;
        if (!done) begin
            n_vec++;
            n_miss++;
            $display("FAIL cmd_done: got no rsp_valid within 800 cycles, want completion");
        end else begin
            @(negedge hclk);
            if (abort) begin
                check("cmd_ready_after_rst", 64'(bus.cmd_ready), 64'(1));
            end else begin
                check("hreq_gap", 64'(bus.hreq), 64'(0));
                check("cmd_ready_after_rsp", 64'(bus.cmd_ready), 64'(1));
            end
        end
    endtask

    initial begin
        logic [3:0] s;
        bus.cmd_valid  = 1'b0;
        bus.cmd_write  = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_wdata  = '0;
        bus.cmd_sel    = 4'h0;
        bus.hgrant     = 1'b0;
        bus.hrdata     = '0;
        bus.hready_out = 1'b1;
        bus.hresp      = 1'b0;

        repeat (3) @(negedge hclk);
        check("reset_cmd_ready", 64'(bus.cmd_ready), 64'(0));
        check("reset_hreq", 64'(bus.hreq), 64'(0));
        check("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("reset_htrans", 64'(bus.htrans), 64'(0));
        hresetn = 1'b1;
        @(negedge hclk);
        check("first_cmd_ready", 64'(bus.cmd_ready), 64'(1));

        run_cmd(1'b0, 32'h0000_0100, 32'h0, 4'h1, 0, 0, 0, 32'hA5A5_0001, 1'b0, 1'b0);
        run_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'h2, 0, 3, 0, 32'h0BAD_0BAD, 1'b0, 1'b0);
        run_cmd(1'b0, 32'h0000_2000, 32'h0, 4'h4, 6, 1, 0, 32'h1234_5678, 1'b0, 1'b0);
        run_cmd(1'b0, 32'h0000_3000, 32'h0, 4'h1, 1, 0, 2, 32'h5555_AAAA, 1'b0, 1'b0);
        run_cmd(1'b0, 32'h0000_3004, 32'h0, 4'h2, 0, 1, 4, 32'hFFFF_0000, 1'b0, 1'b0);
        run_cmd(1'b1, 32'h0000_4000, 32'h1111_2222, 4'h8, 0, 0, 0, 32'h0, 1'b1, 1'b0);
        run_cmd(1'b1, 32'h0000_5000, 32'h3333_4444, 4'h1, 0, 256, 0, 32'h0, 1'b0, 1'b0);
        run_cmd(1'b0, 32'h0000_5004, 32'h0, 4'h2, 0, 255, 0, 32'hCAFE_F00D, 1'b0, 1'b0);
        run_cmd(1'b0, 32'h0000_6000, 32'h0, 4'h1, 0, 2, 0, 32'h7777_8888, 1'b0, 1'b1);
        run_cmd(1'b0, 32'h0000_6004, 32'h0, 4'h1, 0, 0, 0, 32'h9999_AAAA, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            s = 4'(1 << $urandom_range(0, 3));
            run_cmd(1'($urandom_range(0, 1)), $urandom, $urandom, s,
                    is_bridge(s) ? $urandom_range(2, 8) : $urandom_range(0, 2),
                    $urandom_range(0, 4),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0,
                    $urandom, 1'b0, 1'b0);
        end

        repeat (5) @(negedge hclk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
